// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame width and default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with registered head data and valid flag.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = data_q;
    assign valid_o = valid_q;

    // Next pointers and next head; a push into the head slot bypasses the array.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        valid_d  = (wr_ptr_d != rd_ptr_d);
        if (!valid_d) begin
            data_d = '0;
        end else if (push_i && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            data_d = data_i;
        end else begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // Storage array, write only.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizer, start-edge detect, bit-timing FSM and receive FIFO.
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_err_i
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic                      meta_q, sync_q, prev_q;
    rx_state_t                 state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;

    logic start_s, push_req_s, ferr_set_s, ovr_set_s;
    logic pop_s, push_ok_s, fifo_full_s, fifo_valid_s;

    assign start_s     = prev_q & ~sync_q;
    assign pop_s       = fifo_valid_s & ready_i;
    assign push_ok_s   = push_req_s & (~fifo_full_s | pop_s);
    assign ovr_set_s   = push_req_s & fifo_full_s & ~pop_s;
    assign busy_o      = (state_q != RX_IDLE);
    assign valid_o     = fifo_valid_s;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    // Bit-timing FSM: mid-bit sampling, shift-in and stop-bit check.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_req_s = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            RX_IDLE: begin
                baud_d = '0;
                if (start_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    bit_d  = 3'd0;
                    if (!sync_q) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {sync_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (baud_q == BIT_LAST) begin
                    baud_d     = '0;
                    state_d    = RX_IDLE;
                    push_req_s = sync_q;
                    ferr_set_s = ~sync_q;
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_comb begin
        frame_err_d = ferr_set_s | (frame_err_q & ~clr_err_i);
        overrun_d   = ovr_set_s  | (overrun_q   & ~clr_err_i);
    end

    // Synchronizer, edge-detect history and FSM registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q      <= 1'b1;
            sync_q      <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= RX_IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q      <= rx_i;
            sync_q      <= meta_q;
            prev_q      <= sync_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_ok_s),
        .data_i  (shift_q),
        .pop_i   (pop_s),
        .data_o  (data_o),
        .valid_o (fifo_valid_s),
        .full_o  (fifo_full_s)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a queue-based frame model.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int CPB_B = 868;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, ready_a, clr_a;
    logic [7:0] data_a;
    logic       valid_a, busy_a, ferr_a, ovr_a;
    logic       rx_b, ready_b, clr_b;
    logic [7:0] data_b;
    logic       valid_b, busy_b, ferr_b, ovr_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready_a), .busy_o(busy_a), .frame_err_o(ferr_a), .overrun_o(ovr_a),
        .clr_err_i(clr_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) u_dut_baud (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready_b), .busy_o(busy_b), .frame_err_o(ferr_b), .overrun_o(ovr_b),
        .clr_err_i(clr_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic       exp_ferr = 1'b0;
    logic       exp_ovr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One 8N1 frame, bit edges on negedges; optionally pops exactly on the push cycle.
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                              input bit pop_at_push);
        int cpb;
        cpb = sel ? CPB_B : CPB;
        drive(sel, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            repeat (cpb) @(negedge clk);
        end
        drive(sel, stop);
        if (pop_at_push) begin
            repeat (2 + cpb / 2) @(negedge clk);
            ready_a = 1'b1;
            @(negedge clk);
            ready_a = 1'b0;
            repeat (cpb - 3 - cpb / 2) @(negedge clk);
        end else begin
            repeat (cpb) @(negedge clk);
        end
        drive(sel, 1'b1);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        check({tag, "_valid"}, 32'(valid_a), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check({tag, "_data"}, 32'(data_a), 32'(exp_q[0]));
        check({tag, "_ferr"}, 32'(ferr_a), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(ovr_a), 32'(exp_ovr));
    endtask

    task automatic pop_one(input string tag);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        chk_state(tag);
    endtask

    task automatic clear_err();
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        chk_state("clr");
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        bit         seen;
        logic [7:0] seq[4];

        rst = 1'b1; rx_a = 1'b1; ready_a = 1'b0; clr_a = 1'b0;
        rx_b = 1'b1; ready_b = 1'b0; clr_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_ovr", 32'(ovr_a), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, then a pop.
        send_frame(1'b0, 8'h41, 1'b1, 1'b0);
        model_frame(8'h41, 1'b1);
        check("single_lit", 32'(data_a), 32'h41);
        chk_state("single");
        pop_one("single_pop");

        // Back-to-back fill, then overrun.
        seq[0] = 8'h55; seq[1] = 8'hAA; seq[2] = 8'h00; seq[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, seq[i], 1'b1, 1'b0);
            model_frame(seq[i], 1'b1);
        end
        chk_state("b2b_full");
        send_frame(1'b0, 8'h12, 1'b1, 1'b0);
        model_frame(8'h12, 1'b1);
        check("ovr_lit", 32'(ovr_a), 32'd1);
        chk_state("ovr");
        for (int i = 0; i < 4; i++) pop_one("ovr_drain");
        clear_err();

        // Full plus pop on the push cycle.
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, seq[i], 1'b1, 1'b0);
            model_frame(seq[i], 1'b1);
        end
        chk_state("fp_full");
        send_frame(1'b0, 8'h12, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        model_frame(8'h12, 1'b1);
        chk_state("fp_push");
        check("fp_head_lit", 32'(data_a), 32'hAA);
        for (int i = 0; i < 4; i++) pop_one("fp_drain");

        // Framing error, then clear.
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        chk_state("ferr");
        clear_err();

        // Short low glitch.
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_busy_end", 32'(busy_a), 32'd0);
        chk_state("glitch");

        // Reset during data bit 4 with a byte already queued.
        send_frame(1'b0, 8'h99, 1'b1, 1'b0);
        model_frame(8'h99, 1'b1);
        b = 8'h7E;
        rx_a = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_a = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_ferr", 32'(ferr_a), 32'd0);
        rx_a = 1'b1;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_frame(1'b0, 8'h7E, 1'b1, 1'b0);
        model_frame(8'h7E, 1'b1);
        chk_state("post_rst");
        pop_one("post_rst_pop");

        // Random frames, random pops (including pops while empty) and clears.
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(7) != 0);
            send_frame(1'b0, b, stop, 1'b0);
            model_frame(b, stop);
            repeat (($urandom_range(2) + (stop ? 0 : 1)) * CPB) @(negedge clk);
            chk_state("rand");
            for (int p = 0; p < int'($urandom_range(3)); p++) pop_one("rand_pop");
            if ($urandom_range(3) == 0) clear_err();
        end

        // Real baud divisor.
        send_frame(1'b1, 8'h41, 1'b1, 1'b0);
        send_frame(1'b1, 8'h42, 1'b1, 1'b0);
        check("baud_valid", 32'(valid_b), 32'd1);
        check("baud_first", 32'(data_b), 32'h41);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        check("baud_second", 32'(data_b), 32'h42);
        check("baud_ferr", 32'(ferr_b), 32'd0);
        check("baud_ovr", 32'(ovr_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
